// File: rtl/receiver_sequencer.sv
// Receive-chain sequencer: arms the correlator, gathers one demodulated frame
// MSB first, hands it off with valid/ack, and keeps saturating debug counters.
module receiver_sequencer #(
  parameter int PAYLOAD_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     enable,
  input  logic                     corr_done,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  input  logic                     payload_ack,
  output logic                     corr_clr,
  output logic                     demod_init,
  output logic                     demod_stop,
  output logic [PAYLOAD_WIDTH-1:0] payload,
  output logic                     payload_valid,
  output logic [1:0]               state,
  output logic [CNT_WIDTH-1:0]     frame_count,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic [CNT_WIDTH-1:0]     overrun_count
);

  localparam int BW = $clog2(PAYLOAD_WIDTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(PAYLOAD_WIDTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, RECEIVE = 2'd2, HANDOFF = 2'd3} state_t;

  state_t                   st_q, st_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]            timer_q, timer_d;
  // Only PAYLOAD_WIDTH-1 bits are buffered; the last bit goes straight into payload.
  logic [PAYLOAD_WIDTH-2:0] shreg_q, shreg_d;
  logic [PAYLOAD_WIDTH-1:0] shifted;
  logic [PAYLOAD_WIDTH-1:0] payload_d;
  logic                     valid_d, corr_clr_d, demod_init_d, demod_stop_d;
  logic [CNT_WIDTH-1:0]     frame_d, drop_d, overrun_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign state   = st_q;
  assign shifted = {shreg_q, bit_in};

  always_comb begin
    st_d         = st_q;
    bit_cnt_d    = bit_cnt_q;
    timer_d      = timer_q;
    shreg_d      = shreg_q;
    payload_d    = payload;
    valid_d      = payload_valid;
    corr_clr_d   = 1'b0;
    demod_init_d = 1'b0;
    demod_stop_d = 1'b0;
    frame_d      = frame_count;
    drop_d       = drop_count;
    overrun_d    = overrun_count;
    case (st_q)
      IDLE: begin
        if (enable) begin
          st_d       = HUNT;
          corr_clr_d = 1'b1;
        end
      end
      HUNT: begin
        if (!enable) begin
          st_d = IDLE;
        end else if (corr_done) begin
          st_d         = RECEIVE;
          demod_init_d = 1'b1;
          bit_cnt_d    = '0;
          timer_d      = '0;
        end
      end
      RECEIVE: begin
        if (bit_valid) begin
          shreg_d   = shifted[PAYLOAD_WIDTH-2:0];
          bit_cnt_d = bit_cnt_q + BW'(1);
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
        // Completion wins over both abort paths in the same cycle.
        if (bit_valid && bit_cnt_q == BIT_LAST) begin
          st_d         = HANDOFF;
          payload_d    = shifted;
          valid_d      = 1'b1;
          demod_stop_d = 1'b1;
        end else if (!enable) begin
          st_d         = IDLE;
          demod_stop_d = 1'b1;
          drop_d       = sat_inc(drop_count);
        end else if (!bit_valid && timer_q == TMO_LAST) begin
          st_d         = HUNT;
          demod_stop_d = 1'b1;
          corr_clr_d   = 1'b1;
          drop_d       = sat_inc(drop_count);
        end
      end
      HANDOFF: begin
        if (corr_done) overrun_d = sat_inc(overrun_count);
        if (payload_ack) begin
          valid_d = 1'b0;
          frame_d = sat_inc(frame_count);
          if (enable) begin
            st_d       = HUNT;
            corr_clr_d = 1'b1;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st_q          <= IDLE;
      bit_cnt_q     <= '0;
      timer_q       <= '0;
      shreg_q       <= '0;
      payload       <= '0;
      payload_valid <= 1'b0;
      corr_clr      <= 1'b0;
      demod_init    <= 1'b0;
      demod_stop    <= 1'b0;
      frame_count   <= '0;
      drop_count    <= '0;
      overrun_count <= '0;
    end else begin
      st_q          <= st_d;
      bit_cnt_q     <= bit_cnt_d;
      timer_q       <= timer_d;
      shreg_q       <= shreg_d;
      payload       <= payload_d;
      payload_valid <= valid_d;
      corr_clr      <= corr_clr_d;
      demod_init    <= demod_init_d;
      demod_stop    <= demod_stop_d;
      frame_count   <= frame_d;
      drop_count    <= drop_d;
      overrun_count <= overrun_d;
    end
  end

endmodule

// File: tb/tb_receiver_sequencer.sv
// Bench for receiver_sequencer: scenario tasks with random frames, expected
// values derived from the words and event counts the bench itself drives.
module tb_receiver_sequencer;
  localparam int W  = 8;
  localparam int T  = 16;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr, enable, corr_done, bit_valid, bit_in, payload_ack;
  logic          corr_clr, demod_init, demod_stop, payload_valid;
  logic [W-1:0]  payload;
  logic [1:0]    state;
  logic [CW-1:0] frame_count, drop_count, overrun_count;

  int n_checks = 0;
  int n_fail   = 0;

  receiver_sequencer #(.PAYLOAD_WIDTH(W), .TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
    .clk(clk), .clr(clr), .enable(enable), .corr_done(corr_done),
    .bit_valid(bit_valid), .bit_in(bit_in), .payload_ack(payload_ack),
    .corr_clr(corr_clr), .demod_init(demod_init), .demod_stop(demod_stop),
    .payload(payload), .payload_valid(payload_valid), .state(state),
    .frame_count(frame_count), .drop_count(drop_count), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; enable = 1'b0; corr_done = 1'b0; bit_valid = 1'b0;
    bit_in = 1'b0; payload_ack = 1'b0;
    step();
    clr = 1'b0;
  endtask

  // Sends the top n bits of w, MSB first, with random idle gaps below maxgap+1.
  task automatic send_bits(input logic [W-1:0] w, input int n, input int maxgap);
    for (int i = W - 1; i >= W - n; i--) begin
      bit_valid = 1'b0;
      repeat ($urandom_range(maxgap, 0)) step();
      bit_valid = 1'b1;
      bit_in    = w[i];
      step();
      bit_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; enable = 1'b1; corr_done = 1'b1; bit_valid = 1'b1;
    bit_in = 1'b1; payload_ack = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({state, payload, payload_valid, corr_clr, demod_init, demod_stop,
         frame_count, drop_count, overrun_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d payload=%h valid=%b got nonzero, required all 0",
               state, payload, payload_valid);
    end
    clr = 1'b0; enable = 1'b0; corr_done = 1'b0; bit_valid = 1'b0; payload_ack = 1'b0;
    step();
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++; $display("FAIL idle_hold: state=%0d required 0", state);
    end
  endtask

  task automatic test_frame();
    logic [W-1:0] w;
    w = 8'hB2;
    do_reset();
    enable = 1'b1;
    step();
    n_checks++;
    if ({state, corr_clr} !== {2'd1, 1'b1}) begin
      n_fail++; $display("FAIL arm_hunt: state=%0d corr_clr=%b required 1/1", state, corr_clr);
    end
    step();
    n_checks++;
    if (corr_clr !== 1'b0) begin
      n_fail++; $display("FAIL corr_clr_one_cycle: corr_clr=%b required 0", corr_clr);
    end
    bit_valid = 1'b1; bit_in = 1'b1;
    step();
    bit_valid = 1'b0;
    n_checks++;
    if (state !== 2'd1) begin
      n_fail++; $display("FAIL hunt_ignores_bits: state=%0d required 1", state);
    end
    corr_done = 1'b1;
    step();
    corr_done = 1'b0;
    n_checks++;
    if ({state, demod_init} !== {2'd2, 1'b1}) begin
      n_fail++; $display("FAIL demod_init: state=%0d demod_init=%b required 2/1", state, demod_init);
    end
    send_bits(w, W, 0);
    n_checks++;
    if ({payload, payload_valid, demod_stop, state} !== {w, 1'b1, 1'b1, 2'd3}) begin
      n_fail++;
      $display("FAIL frame_b2: payload=%h valid=%b stop=%b state=%0d required %h/1/1/3",
               payload, payload_valid, demod_stop, state, w);
    end
    step();
    n_checks++;
    if ({demod_stop, payload_valid} !== 2'b01) begin
      n_fail++; $display("FAIL stop_one_cycle: stop=%b valid=%b required 0/1", demod_stop, payload_valid);
    end
    payload_ack = 1'b1;
    step();
    payload_ack = 1'b0;
    n_checks++;
    if ({payload_valid, frame_count, state, corr_clr} !== {1'b0, 2'd1, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL ack_release: valid=%b frames=%0d state=%0d corr_clr=%b required 0/1/1/1",
               payload_valid, frame_count, state, corr_clr);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] w;
    int early;
    w = W'($urandom);
    early = 0;
    do_reset();
    enable = 1'b1;
    step();
    corr_done = 1'b1;
    step();
    corr_done = 1'b0;
    send_bits(w, 3, 4);
    repeat (T - 1) begin
      step();
      if (state !== 2'd2 || demod_stop !== 1'b0) early++;
    end
    n_checks++;
    if (early != 0) begin
      n_fail++; $display("FAIL timeout_early: %0d early cycles, required 0", early);
    end
    step();
    n_checks++;
    if ({state, drop_count, corr_clr, demod_stop, payload_valid, payload} !==
        {2'd1, 2'd1, 1'b1, 1'b1, 1'b0, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL timeout: state=%0d drops=%0d clr=%b stop=%b valid=%b payload=%h required 1/1/1/1/0/00",
               state, drop_count, corr_clr, demod_stop, payload_valid, payload);
    end
  endtask

  task automatic test_handoff_hold();
    logic [W-1:0] w;
    int bad;
    w = W'($urandom);
    bad = 0;
    do_reset();
    enable = 1'b1;
    step();
    corr_done = 1'b1;
    step();
    corr_done = 1'b0;
    send_bits(w, W, 3);
    for (int c = 0; c < 50; c++) begin
      corr_done = (c == 5 || c == 20 || c == 35);
      step();
      if ({payload, payload_valid, state} !== {w, 1'b1, 2'd3}) bad++;
    end
    corr_done = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL handoff_stable: %0d unstable cycles, required 0", bad);
    end
    n_checks++;
    if (overrun_count !== 2'd3) begin
      n_fail++; $display("FAIL overrun: got %0d required 3", overrun_count);
    end
    payload_ack = 1'b1;
    step();
    payload_ack = 1'b0;
    n_checks++;
    if ({state, payload_valid, frame_count} !== {2'd1, 1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL handoff_release: state=%0d valid=%b frames=%0d required 1/0/1",
               state, payload_valid, frame_count);
    end
  endtask

  task automatic test_enable_drop();
    logic [W-1:0] w;
    w = W'($urandom);
    do_reset();
    enable = 1'b1;
    step();
    corr_done = 1'b1;
    step();
    corr_done = 1'b0;
    send_bits(w, 3, 2);
    enable = 1'b0;
    step();
    n_checks++;
    if ({state, drop_count, demod_stop} !== {2'd0, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL enable_drop_rx: state=%0d drops=%0d stop=%b required 0/1/1",
               state, drop_count, demod_stop);
    end
    enable = 1'b1;
    step();
    corr_done = 1'b1;
    step();
    corr_done = 1'b0;
    send_bits(w, W - 1, 2);
    // Last bit coincides with enable falling: the frame still completes.
    enable = 1'b0; bit_valid = 1'b1; bit_in = w[0];
    step();
    bit_valid = 1'b0;
    n_checks++;
    if ({state, payload, drop_count} !== {2'd3, w, 2'd1}) begin
      n_fail++;
      $display("FAIL complete_priority: state=%0d payload=%h drops=%0d required 3/%h/1",
               state, payload, drop_count, w);
    end
    repeat (4) step();
    payload_ack = 1'b1;
    step();
    payload_ack = 1'b0;
    n_checks++;
    if ({state, frame_count, payload_valid, corr_clr} !== {2'd0, 2'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL handoff_to_idle: state=%0d frames=%0d valid=%b clr=%b required 0/1/0/0",
               state, frame_count, payload_valid, corr_clr);
    end
  endtask

  task automatic test_clr_mid();
    logic [W-1:0] w;
    w = W'($urandom);
    do_reset();
    enable = 1'b1;
    step();
    corr_done = 1'b1;
    step();
    corr_done = 1'b0;
    send_bits(w, W, 1);
    clr = 1'b1; corr_done = 1'b1;
    step();
    clr = 1'b0; corr_done = 1'b0;
    n_checks++;
    if ({state, payload, payload_valid, corr_clr, demod_init, demod_stop,
         frame_count, drop_count, overrun_count} !== '0) begin
      n_fail++;
      $display("FAIL clr_handoff: state=%0d payload=%h valid=%b required all 0", state, payload, payload_valid);
    end
    step();
    corr_done = 1'b1;
    step();
    corr_done = 1'b0;
    send_bits(w, 2, 1);
    clr = 1'b1; bit_valid = 1'b1;
    step();
    clr = 1'b0; bit_valid = 1'b0;
    n_checks++;
    if ({state, payload, payload_valid, corr_clr, demod_init, demod_stop,
         frame_count, drop_count, overrun_count} !== '0) begin
      n_fail++;
      $display("FAIL clr_receive: state=%0d stop=%b drops=%0d required all 0", state, demod_stop, drop_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    int exp_frames;
    do_reset();
    enable = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      w = W'($urandom);
      corr_done = 1'b1;
      step();
      corr_done = 1'b0;
      send_bits(w, W, 5);
      n_checks++;
      if ({payload, payload_valid} !== {w, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_payload[%0d]: payload=%h valid=%b required %h/1", k, payload, payload_valid, w);
      end
      repeat ($urandom_range(4, 0)) step();
      payload_ack = 1'b1;
      step();
      payload_ack = 1'b0;
      exp_frames = (k > CMAX) ? CMAX : k;
      n_checks++;
      if ({frame_count, state} !== {CW'(exp_frames), 2'd1}) begin
        n_fail++;
        $display("FAIL b2b_frames[%0d]: frames=%0d state=%0d required %0d/1",
                 k, frame_count, state, exp_frames);
      end
    end
  endtask

  initial begin
    clr = 1'b1; enable = 1'b0; corr_done = 1'b0; bit_valid = 1'b0;
    bit_in = 1'b0; payload_ack = 1'b0;
    test_reset();
    test_frame();
    test_timeout();
    test_handoff_hold();
    test_enable_drop();
    test_clr_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
